// File: rtl/tmr_voter_n.sv
// tmr_voter_n: registered triple-modular-redundancy word voter with
// per-channel fault tracking.
//
// Each valid sample of the three redundant channels a/b/c (index 0/1/2)
// yields a voted word one cycle later. A channel that disagrees with the
// raw bitwise majority on FAULT_THRESH consecutive valid samples is flagged
// faulty and dropped from selection until fault_clr.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid            a/b/c carry a sample this cycle
//   a, b, c             redundant channel words
//   fault_clr           clears chan_fault, run counters, error counters
//   out_valid           vote/mismatch/no_agree valid this cycle
//   vote                voted word (held when no selection is possible)
//   mismatch            per channel, differed from the majority on the sample
//   no_agree            degraded vote could not be formed, vote held
//   chan_fault          sticky per-channel fault flags
//   fail                all three channels faulted
//   err_cnt_a/b/c       saturating disagreement counts
module tmr_voter_n #(
  parameter int WIDTH        = 8,
  parameter int FAULT_THRESH = 4,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             fault_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] vote,
  output logic [2:0]       mismatch,
  output logic             no_agree,
  output logic [2:0]       chan_fault,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c
);

  localparam int RUN_W = (FAULT_THRESH < 1) ? 1 : $clog2(FAULT_THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAULT_THRESH);
  localparam logic [RUN_W-1:0] RUN_SET = RUN_W'(FAULT_THRESH - 1);

  logic [WIDTH-1:0] ch [3];
  logic [WIDTH-1:0] maj;
  logic [2:0]       dis;
  logic [WIDTH-1:0] sel_word;
  logic             sel_ok;

  logic [RUN_W-1:0] run [3];
  logic [CNT_W-1:0] err [3];

  assign ch[0] = a;
  assign ch[1] = b;
  assign ch[2] = c;

  // Majority is always taken from the raw inputs, so a faulted channel
  // still keeps being compared (and counted) against it.
  assign maj = (a & b) | (b & c) | (a & c);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dis[i] = in_valid & (ch[i] != maj);
    end
  end

  // Selection from the healthy set, based on the registered fault flags.
  always_comb begin
    sel_word = maj;
    sel_ok   = 1'b1;
    case (~chan_fault)
      3'b111: begin sel_word = maj;  sel_ok = 1'b1;       end
      3'b011: begin sel_word = a;    sel_ok = (a == b);   end
      3'b101: begin sel_word = a;    sel_ok = (a == c);   end
      3'b110: begin sel_word = b;    sel_ok = (b == c);   end
      3'b001: begin sel_word = a;    sel_ok = 1'b1;       end
      3'b010: begin sel_word = b;    sel_ok = 1'b1;       end
      3'b100: begin sel_word = c;    sel_ok = 1'b1;       end
      default: begin sel_word = maj; sel_ok = 1'b0;       end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      vote       <= '0;
      mismatch   <= '0;
      no_agree   <= 1'b0;
      chan_fault <= '0;
      for (int i = 0; i < 3; i++) begin
        run[i] <= '0;
        err[i] <= '0;
      end
    end else begin
      out_valid <= in_valid;
      mismatch  <= dis;
      no_agree  <= in_valid & ~sel_ok;
      if (in_valid && sel_ok) vote <= sel_word;

      for (int i = 0; i < 3; i++) begin
        if (fault_clr) begin
          run[i]        <= '0;
          err[i]        <= '0;
          chan_fault[i] <= 1'b0;
        end else if (in_valid) begin
          if (dis[i]) begin
            if (run[i] != RUN_MAX) run[i] <= run[i] + RUN_W'(1);
            if (run[i] == RUN_SET) chan_fault[i] <= 1'b1;
            if (err[i] != {CNT_W{1'b1}}) err[i] <= err[i] + CNT_W'(1);
          end else begin
            run[i] <= '0;
          end
        end
      end
    end
  end

  assign fail      = &chan_fault;
  assign err_cnt_a = err[0];
  assign err_cnt_b = err[1];
  assign err_cnt_c = err[2];

endmodule

// File: tb/tb_tmr_voter_n.sv
// Testbench for tmr_voter_n: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model of the voting and fault rules.
module tb_tmr_voter_n;

  localparam int W   = 8;
  localparam int FT  = 4;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic         fault_clr = 1'b0;
  logic         out_valid;
  logic [W-1:0] vote;
  logic [2:0]   mismatch;
  logic         no_agree;
  logic [2:0]   chan_fault;
  logic         fail;
  logic [CW-1:0] err_cnt_a, err_cnt_b, err_cnt_c;

  int checks = 0;
  int failures = 0;

  tmr_voter_n #(.WIDTH(W), .FAULT_THRESH(FT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .fault_clr(fault_clr),
    .out_valid(out_valid), .vote(vote), .mismatch(mismatch),
    .no_agree(no_agree), .chan_fault(chan_fault), .fail(fail),
    .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int           m_run [3];
  int           m_err [3];
  bit   [2:0]   m_fault;
  logic [W-1:0] m_vote;
  bit           m_ov, m_na;
  bit   [2:0]   m_mm;
  bit           armed = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] w [3];
    logic [W-1:0] mj;
    logic [W-1:0] healthy [$];
    w[0] = a; w[1] = b; w[2] = c;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin m_run[i] = 0; m_err[i] = 0; end
      m_fault = '0; m_vote = '0; m_ov = 0; m_na = 0; m_mm = '0;
      armed = 1'b1;
    end else begin
      // bitwise majority: a bit is 1 when at least two channels have it
      for (int k = 0; k < W; k++)
        mj[k] = (int'(a[k]) + int'(b[k]) + int'(c[k])) >= 2;
      m_ov = in_valid;
      m_na = 0;
      m_mm = '0;
      if (in_valid) begin
        healthy.delete();
        for (int i = 0; i < 3; i++) if (!m_fault[i]) healthy.push_back(w[i]);
        if (healthy.size() == 3) m_vote = mj;
        else if (healthy.size() == 2) begin
          if (healthy[0] == healthy[1]) m_vote = healthy[0];
          else m_na = 1;
        end else if (healthy.size() == 1) m_vote = healthy[0];
        else m_na = 1;
        for (int i = 0; i < 3; i++) begin
          if (w[i] != mj) begin
            m_mm[i] = 1;
            m_err[i] = (m_err[i] + 1 > SAT) ? SAT : m_err[i] + 1;
            m_run[i] = (m_run[i] + 1 > FT) ? FT : m_run[i] + 1;
            if (m_run[i] >= FT) m_fault[i] = 1;
          end else begin
            m_run[i] = 0;
          end
        end
      end
      if (fault_clr) begin
        for (int i = 0; i < 3; i++) begin m_run[i] = 0; m_err[i] = 0; end
        m_fault = '0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("vote", 32'(vote), 32'(m_vote));
      chk("mismatch", 32'(mismatch), 32'(m_mm));
      chk("no_agree", 32'(no_agree), 32'(m_na));
      chk("chan_fault", 32'(chan_fault), 32'(m_fault));
      chk("fail", 32'(fail), 32'(&m_fault));
      chk("err_cnt_a", 32'(err_cnt_a), 32'(m_err[0]));
      chk("err_cnt_b", 32'(err_cnt_b), 32'(m_err[1]));
      chk("err_cnt_c", 32'(err_cnt_c), 32'(m_err[2]));
    end
  end

  // Drive one cycle of inputs (called at a negedge, returns at the next).
  task automatic step(input bit v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                      input logic [W-1:0] xc, input bit clr = 0, input bit r = 0);
    in_valid = v; a = xa; b = xb; c = xc; fault_clr = clr; rst = r;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] rv, fx;
    @(negedge clk);
    step(0, 8'h00, 8'h00, 8'h00, 0, 1);
    step(1, 8'hAA, 8'h55, 8'h0F, 1, 1);  // sample during reset is discarded
    chk("rst_vote", 32'(vote), 32'h0);
    chk("rst_ov", 32'(out_valid), 32'h0);

    // 1. all agree
    step(1, 8'h5A, 8'h5A, 8'h5A);
    chk("t1_vote", 32'(vote), 32'h5A);
    chk("t1_ov", 32'(out_valid), 32'h1);
    chk("t1_mm", 32'(mismatch), 32'h0);
    step(0, 8'h00, 8'h00, 8'h00);
    chk("t1_ov_idle", 32'(out_valid), 32'h0);

    // 2. bitwise majority
    step(1, 8'hFF, 8'h0F, 8'hF0);
    chk("t2_vote", 32'(vote), 32'hFF);
    chk("t2_mm", 32'(mismatch), 32'h6);
    chk("t2_errb", 32'(err_cnt_b), 32'h1);
    chk("t2_errc", 32'(err_cnt_c), 32'h1);

    // 3. threshold and run reset
    step(0, 8'h00, 8'h00, 8'h00, 1);
    repeat (3) step(1, 8'h3C, 8'h3C, 8'h00);
    step(1, 8'h3C, 8'h3C, 8'h3C);
    chk("t3_nofault", 32'(chan_fault), 32'h0);
    chk("t3_errc3", 32'(err_cnt_c), 32'h3);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h3C, 8'h3C, 8'h00);
      step(0, 8'h00, 8'h00, 8'h00);
    end
    chk("t3_nofault3", 32'(chan_fault), 32'h0);
    step(1, 8'h3C, 8'h3C, 8'h00);
    chk("t3_fault_c", 32'(chan_fault), 32'h4);

    // 4. degraded voting with c faulted
    step(1, 8'h11, 8'h22, 8'h11);
    chk("t4_hold", 32'(vote), 32'h3C);
    chk("t4_na", 32'(no_agree), 32'h1);
    step(1, 8'h33, 8'h33, 8'h00);
    chk("t4_vote33", 32'(vote), 32'h33);
    repeat (4) step(1, 8'h00, 8'h33, 8'h33);
    chk("t4_fault_ac", 32'(chan_fault), 32'h5);
    repeat (4) step(1, 8'h33, 8'h00, 8'h33);
    chk("t4_fail", 32'(fail), 32'h1);
    chk("t4_vote_b", 32'(vote), 32'h00);
    step(1, 8'h12, 8'h34, 8'h56);
    chk("t4_fail_na", 32'(no_agree), 32'h1);
    chk("t4_fail_hold", 32'(vote), 32'h00);

    // 5. fault_clr colliding with the 4th disagreement of a
    step(0, 8'h00, 8'h00, 8'h00, 1);
    repeat (3) step(1, 8'h00, 8'h77, 8'h77);
    step(1, 8'h00, 8'h77, 8'h77, 1);
    chk("t5_fault", 32'(chan_fault), 32'h0);
    chk("t5_erra", 32'(err_cnt_a), 32'h0);
    step(1, 8'h01, 8'h02, 8'h03);
    chk("t5_maj", 32'(vote), 32'h03);

    // 6. saturation then mid-stream reset
    for (int i = 0; i < 300; i++) begin
      rv = W'($urandom);
      fx = W'($urandom_range(1, 255));
      step(1, rv ^ fx, rv, rv);
    end
    chk("t6_sat", 32'(err_cnt_a), 32'(SAT));
    chk("t6_fault_a", 32'(chan_fault[0]), 32'h1);
    step(1, 8'h99, 8'h98, 8'h97, 0, 1);
    chk("t6_rst_ov", 32'(out_valid), 32'h0);
    chk("t6_rst_vote", 32'(vote), 32'h0);
    chk("t6_rst_fault", 32'(chan_fault), 32'h0);
    chk("t6_rst_erra", 32'(err_cnt_a), 32'h0);
    step(1, 8'h0C, 8'h0A, 8'h09);
    chk("t6_resume", 32'(vote), 32'h08);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] w [3];
      rv = W'($urandom);
      for (int i = 0; i < 3; i++) begin
        w[i] = rv;
        if ($urandom_range(0, 5) == 0) w[i] = rv ^ W'($urandom);
      end
      step(($urandom_range(0, 9) < 8), w[0], w[1], w[2],
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 299) == 0));
    end

    step(0, 8'h00, 8'h00, 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tmr_voter_n.md
# tmr_voter_n

Parametrised, registered triple-modular-redundancy word voter with per-channel fault tracking. It is the multi-bit successor to the single-bit 2-of-3 majority gate. Each valid sample of three redundant `WIDTH`-bit channels produces a bitwise majority word. A channel that disagrees with the majority for `FAULT_THRESH` consecutive valid samples is excluded until it is cleared, and voting then degrades to the remaining healthy channels. The block sits between the redundant sources and the consuming logic or LEDs.

## Interface
- `WIDTH`, 8: width of each channel word and of the vote.
- `FAULT_THRESH`, 4: consecutive disagreeing valid samples needed to declare a channel faulty; range ≥1.
- `CNT_W`, 8: width of each saturating error counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a/b/c hold a sample this cycle.
- `a`, `b`, `c`  in  WIDTH  redundant channel words; channel index 0/1/2.
- `fault_clr`  in  1  clears `chan_fault`, run counters and error counters.
- `out_valid`  out  1  `vote`/`mismatch`/`no_agree` are valid this cycle.
- `vote`  out  WIDTH  voted word.
- `mismatch`  out  3  per channel, that channel differed from `maj` on the sample.
- `no_agree`  out  1  a degraded vote could not be formed; `vote` held.
- `chan_fault`  out  3  sticky per-channel fault flags.
- `fail`  out  1  all three channels are faulted (`&chan_fault`).
- `err_cnt_a`, `err_cnt_b`, `err_cnt_c`  out  CNT_W  saturating disagreement counts.

## Operation
- `maj = (a&b)|(b&c)|(a&c)` is computed bitwise from the raw inputs, regardless of fault state.
- `dis_x = in_valid & (x != maj)` is a word compare.
- **Run counter `run_x`** (0..FAULT_THRESH), updated only on valid samples:
  - when `dis_x` is set, it increments and saturates;
  - otherwise it is cleared to 0.
  - Non-valid cycles hold it.
- **Fault set:** `chan_fault[x]` is set on the valid sample where `dis_x` is true and `run_x == FAULT_THRESH-1`. It stays set until `fault_clr` or `rst`.
- **Error counter:** `err_cnt_x` increments on every valid sample with `dis_x` and saturates at 2^CNT_W-1. It keeps counting after the channel is faulted.
- **Vote selection** uses the registered `chan_fault` (the value before this cycle's update). With h = number of healthy channels:
  - h=3: `vote <= maj`.
  - h=2: if the two healthy words are equal, `vote <=` that word. Otherwise `vote` holds and `no_agree` is set.
  - h=1: `vote <=` the healthy channel.
  - h=0: `vote` holds and `no_agree` is set.
- `vote` changes only on valid samples.
- **`fault_clr` priority:** it beats any simultaneous fault set or counter increment. In that cycle the run counters, error counters and `chan_fault` all go to 0. `vote` still updates from that cycle's sample.

## Timing
- Latency is one cycle: `out_valid` at cycle n+1 equals `in_valid` at cycle n.
- `vote`, `mismatch` and `no_agree` are registered in the same cycle as `out_valid`.
- `mismatch` and `no_agree` are 0 whenever `out_valid` is 0 (single-cycle pulses).
- `chan_fault` rises on the clock edge that captures the FAULT_THRESH-th consecutive disagreeing sample, i.e. together with that sample's `out_valid`.
- A channel newly faulted by a sample affects selection from the next sample onward. That sample itself was voted with h from before.
- `fail` is combinational from registered `chan_fault` and carries no extra delay.
- `rst`: all outputs, run counters and error counters are 0 on the next edge. This includes `vote`=0 and `out_valid`=0.
- `rst` overrides `in_valid` and `fault_clr`. A sample presented during `rst` is discarded.

## Test plan
1. **All channels agree:** reset, then a=b=c=0x5A with `in_valid` for 1 cycle → next cycle `out_valid`=1, `vote`=0x5A, `mismatch`=000, `no_agree`=0.
2. **Bitwise majority:** a=0xFF, b=0x0F, c=0xF0 → `vote`=0xFF, `mismatch`=3'b110, and `err_cnt_b`=`err_cnt_c`=1.
3. **Fault threshold and run reset:**
   - c=0x00 with a=b=0x3C for 3 valid samples, then one good sample → no fault, `err_cnt_c`=3.
   - Then 4 consecutive bad samples, with idle cycles in between → `chan_fault`=3'b100 on the 4th sample's output cycle.
4. **Degraded voting** (c faulted):
   - a=0x11, b=0x22, c=0x11 → `vote` holds its previous value, `no_agree`=1.
   - Then a=b=0x33, c=0x00 → `vote`=0x33.
   - Fault a and b as well → `fail`=1, and `vote` holds with `no_agree` on every valid sample.
5. **`fault_clr` collision:** `fault_clr` asserted in the same cycle as the 4th disagreeing sample of channel a → `chan_fault[0]` stays 0 and `err_cnt_a`=0. The next sample votes from `maj` (h=3).
6. **Counter saturation and mid-run reset:**
   - 300 valid samples with a disagreeing → `err_cnt_a`=255 and `chan_fault[0]`=1.
   - Assert `rst` for 1 cycle mid-stream → all outputs 0 on the following cycle, and normal voting resumes on the next valid sample.
